alu_issue_seq: RTL and testbench
================================

// Module: alu_issue_seq
// PURPOSE
//  Registered ALU-issue stage between decode and execute. Decodes the instruction class into ALU opcode
//  and per-flag write enables, like the combinational decoder it replaces, and adds a third class:
//  iterative multiply / multiply-accumulate (MUL/MLA), sequenced over several cycles.
//  Uses valid/ready handshakes on both sides so execute can stall it and it can stall decode.
// PARAMETERS
//  DATAW    32  operand/result width; multiply runs DATAW iterations (1 multiplier bit/cycle)
//  FLAGSW    4  CPSR flag count, order {N,Z,C,V} MSB..LSB
//  CONTROLW  4  control field width (ctrl[0]=S/bit20, ctrl[1]=A/bit21, ctrl[2]=B/bit22, ctrl[3]=U/bit23)
//  ALUAW     3  ALU opcode width; DATA opcode is ctrl[1 +: ALUAW]
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         decode presents an instruction
//  in_ready   out  1         stage accepts this cycle
//  optype     in   2         0=DATA, 1=LDSTR, 2=MUL, 3=reserved (treated as DATA with flag_we=0)
//  ctrl       in   CONTROLW  control bits as above
//  op_a       in   DATAW     multiplicand (MUL)
//  op_b       in   DATAW     multiplier (MUL)
//  op_c       in   DATAW     accumulator (MLA)
//  out_valid  out  1         issue word valid
//  out_ready  in   1         execute consumes issue word
//  alu_opcode out  ALUAW     opcode to ALU
//  flag_we    out  FLAGSW    per-flag CPSR write enable
//  byte_en    out  1         LDSTR byte access (ctrl[2])
//  is_mul     out  1         mul_result is the result; ALU bypassed
//  mul_result out  DATAW     low DATAW bits of op_a*op_b (+op_c if MLA)
//  busy       out  1         multiply sequence in progress
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, alu_opcode, flag_we, byte_en, is_mul, mul_result, busy all 0.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  DATA accept: next cycle out_valid=1, alu_opcode=ctrl[1+:ALUAW], flag_we=ctrl[0]?all-ones:0,
//   byte_en=0, is_mul=0. Latency 1.
//  LDSTR accept: alu_opcode = ctrl[3]?ADD:SUB, flag_we=0, byte_en=ctrl[2], is_mul=0. Latency 1.
//  MUL accept: state->MUL, busy=1, acc<=ctrl[1]?op_c:0, mcand<=op_a, mplier<=op_b, cnt<=0;
//   out_valid drops to 0 if previous word consumed this cycle.
//  MUL state each cycle: if mplier[0] acc+=mcand; mcand<<=1; mplier>>=1; cnt++.
//   After DATAW iterations -> IDLE, out_valid=1, is_mul=1, mul_result=acc, alu_opcode=ADD,
//   flag_we = ctrl[0] ? {N,Z}=1,{C,V}=0 : 0. Latency DATAW+1 cycles accept->out_valid.
//  All arithmetic modulo 2^DATAW; overflow bits discarded; no flag values computed here.
//  Output hold: while out_valid && !out_ready every output is stable; no new accept.
//  Simultaneous out_ready and accept in IDLE: old word retires, new word loads same edge.
//  in_valid during MUL: ignored (in_ready=0); decode must hold.
//  optype=3: out_valid pulses like DATA with flag_we=0, is_mul=0 (safe NOP).
//  Reset mid-MUL: async abort to IDLE, partial product discarded, outputs to reset values.
// CONFIGURATION
//  MUL_EARLY_TERM_EN defined: MUL completes when remaining multiplier bits are zero (after >=1
//   iteration); op_b=0 -> out_valid 2 cycles after accept; op_b=1 -> 2 cycles; op_b=0x80000000 -> 33.
//  Undefined: fixed DATAW iterations for every multiply; result identical either way.
// STRUCTURE
//  Shared defines: ADD/SUB opcode encodings, ALUAW, FLAGSW, CONTROLW, optype codes (OPT_DATA,
//   OPT_LDSTR, OPT_MUL), control bit indices (S_i, A_i, B_i, U_i), flag indices (N_i,Z_i,C_i,V_i).
//  Sub-module mul_iter: shift-add datapath + counter, start/done handshake, DATAW param, owns
//   early-termination logic. Top holds FSM (IDLE/MUL), handshakes, output register.
// TESTING
//  DATA ctrl=4'b1011 (op=5,S=1), out_ready=1 -> 1 cycle later out_valid, alu_opcode=5, flag_we=4'hF.
//  LDSTR ctrl[3]=0, ctrl[2]=1 -> alu_opcode=SUB, byte_en=1, flag_we=0; ctrl[3]=1 -> ADD.
//  MUL op_a=7, op_b=6, S=1 -> mul_result=42, flag_we=4'b1100, out_valid at cycle 33 (fixed mode).
//  MLA op_a=0xFFFFFFFF, op_b=2, op_c=5 -> mul_result=0x00000003 (wrap); in_ready=0 while busy.
//  Stall: out_ready=0 for 5 cycles after DATA -> outputs stable, in_ready=0; then back-to-back accepts.
//  Assert rst at MUL cycle 10 -> busy=0, out_valid=0 immediately; next DATA issues normally.

Source files
------------

// File: rtl/alu_issue_seq_pkg.sv
`default_nettype none
// ============================================================================
// alu_issue_seq_pkg
// Shared encodings for the ALU-issue stage: field widths, instruction
// class codes, control/flag bit positions and the issue FSM states.
// Revision: 1.0  initial release
// ============================================================================
package alu_issue_seq_pkg;

  localparam int FLAGSW   = 4;  // {N,Z,C,V} MSB..LSB
  localparam int CONTROLW = 4;
  localparam int ALUAW    = 3;

  // ALU opcode encodings used for address generation and multiply issue
  localparam logic [ALUAW-1:0] ALU_SUB = 3'd2;
  localparam logic [ALUAW-1:0] ALU_ADD = 3'd4;

  // Control bit positions
  localparam int S_i = 0;
  localparam int A_i = 1;
  localparam int B_i = 2;
  localparam int U_i = 3;

  // Flag bit positions
  localparam int N_i = 3;
  localparam int Z_i = 2;
  localparam int C_i = 1;
  localparam int V_i = 0;

  // Multiply with S set only updates N and Z
  localparam logic [FLAGSW-1:0] FLAGS_NZ = FLAGSW'((1 << N_i) | (1 << Z_i));

  typedef enum logic [1:0] {
    OPT_DATA  = 2'd0,
    OPT_LDSTR = 2'd1,
    OPT_MUL   = 2'd2,
    OPT_RSVD  = 2'd3
  } optype_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage : alu_issue_seq_pkg
`default_nettype wire

// File: rtl/alu_issue_seq_mul_iter.sv
`default_nettype none
// ============================================================================
// mul_iter
// Shift-add multiplier, one multiplier bit per cycle. A start pulse loads
// the operands; done is high for one cycle once the product is in result.
// Build option MUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero (at least one iteration is always run).
// Revision: 1.0  initial release
// ============================================================================
module mul_iter #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DATAW-1:0] mcand_in,
  input  logic [DATAW-1:0] mplier_in,
  input  logic [DATAW-1:0] acc_in,
  output logic             done,
  output logic [DATAW-1:0] result
);

  localparam int CNTW = $clog2(DATAW + 1);

  logic             running;
  logic [DATAW-1:0] acc;
  logic [DATAW-1:0] mcand;
  logic [DATAW-1:0] mplier;
  logic [CNTW-1:0]  cnt;

`ifdef MUL_EARLY_TERM_EN
  // Once the multiplier is exhausted further iterations add nothing
  assign done = running && (cnt != '0) && ((cnt == CNTW'(DATAW)) || (mplier == '0));
`else
  assign done = running && (cnt == CNTW'(DATAW));
`endif

  assign result = acc;

  // Load on start, then one conditional add and shift per cycle until done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      acc     <= acc_in;
      mcand   <= mcand_in;
      mplier  <= mplier_in;
      cnt     <= '0;
    end else if (done) begin
      running <= 1'b0;
    end else if (running) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNTW'(1);
    end
  end

endmodule : mul_iter
`default_nettype wire

// File: rtl/alu_issue_seq.sv
`default_nettype none
// ============================================================================
// alu_issue_seq
// Registered ALU-issue stage: decodes DATA / LDSTR into an ALU opcode and
// flag write enables with one cycle latency, and sequences MUL/MLA through
// mul_iter. Valid/ready on both sides; the output word holds while stalled.
// Build option MUL_EARLY_TERM_EN: early multiply completion in mul_iter.
// Revision: 1.0  initial release
// ============================================================================
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int DATAW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          optype,
  input  logic [CONTROLW-1:0] ctrl,
  input  logic [DATAW-1:0]    op_a,
  input  logic [DATAW-1:0]    op_b,
  input  logic [DATAW-1:0]    op_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUAW-1:0]    alu_opcode,
  output logic [FLAGSW-1:0]   flag_we,
  output logic                byte_en,
  output logic                is_mul,
  output logic [DATAW-1:0]    mul_result,
  output logic                busy
);

  state_t             state, state_nx;
  logic               valid_nx;
  logic [ALUAW-1:0]   opcode_nx;
  logic [FLAGSW-1:0]  flags_nx;
  logic               byte_nx;
  logic               mul_nx;
  logic [DATAW-1:0]   result_nx;
  logic               mul_s;
  logic               mul_done;
  logic [DATAW-1:0]   mul_acc;
  logic               accept;
  logic               mul_start;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (optype == OPT_MUL);
  assign busy      = (state == ST_MUL);

  mul_iter #(.DATAW(DATAW)) u_mul_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .mcand_in  (op_a),
    .mplier_in (op_b),
    .acc_in    (ctrl[A_i] ? op_c : '0),
    .done      (mul_done),
    .result    (mul_acc)
  );

  // Next state and next issue word; by default the word holds and valid
  // drops only when execute takes it
  always_comb begin
    state_nx  = state;
    valid_nx  = out_valid && !out_ready;
    opcode_nx = alu_opcode;
    flags_nx  = flag_we;
    byte_nx   = byte_en;
    mul_nx    = is_mul;
    result_nx = mul_result;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (optype == OPT_MUL) begin
            state_nx = ST_MUL;
          end else if (optype == OPT_LDSTR) begin
            valid_nx  = 1'b1;
            opcode_nx = ctrl[U_i] ? ALU_ADD : ALU_SUB;
            flags_nx  = '0;
            byte_nx   = ctrl[B_i];
            mul_nx    = 1'b0;
          end else begin
            // DATA, and the reserved class as a flag-free NOP
            valid_nx  = 1'b1;
            opcode_nx = ctrl[A_i +: ALUAW];
            flags_nx  = ((optype == OPT_DATA) && ctrl[S_i]) ? '1 : '0;
            byte_nx   = 1'b0;
            mul_nx    = 1'b0;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_nx  = ST_IDLE;
          valid_nx  = 1'b1;
          opcode_nx = ALU_ADD;
          flags_nx  = mul_s ? FLAGS_NZ : '0;
          byte_nx   = 1'b0;
          mul_nx    = 1'b1;
          result_nx = mul_acc;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Issue word register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_opcode <= '0;
      flag_we    <= '0;
      byte_en    <= 1'b0;
      is_mul     <= 1'b0;
      mul_result <= '0;
    end else begin
      out_valid  <= valid_nx;
      alu_opcode <= opcode_nx;
      flag_we    <= flags_nx;
      byte_en    <= byte_nx;
      is_mul     <= mul_nx;
      mul_result <= result_nx;
    end
  end

  // S bit of the multiply in flight, needed when the result issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            mul_s <= 1'b0;
    else if (mul_start) mul_s <= ctrl[S_i];
  end

endmodule : alu_issue_seq
`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_seq
// Self-checking bench for alu_issue_seq: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_issue_seq;
  import alu_issue_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  optype;
  logic [3:0]  ctrl;
  logic [31:0] op_a, op_b, op_c;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_opcode;
  logic [3:0]  flag_we;
  logic        byte_en;
  logic        is_mul;
  logic [31:0] mul_result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  alu_issue_seq #(.DATAW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .optype(optype), .ctrl(ctrl), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opcode(alu_opcode),
    .flag_we(flag_we), .byte_en(byte_en), .is_mul(is_mul),
    .mul_result(mul_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: pending issue word plus a countdown for the multiply in flight
  bit          m_valid;
  logic [2:0]  m_op;
  logic [3:0]  m_flags;
  bit          m_byte;
  bit          m_mul;
  logic [31:0] m_res;
  int          m_pending;
  logic [31:0] p_res;
  logic [3:0]  p_flags;
  bit          m_accepted;

`ifdef MUL_EARLY_TERM_EN
  localparam int LAT_7X6 = 4;
`else
  localparam int LAT_7X6 = 33;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles from accept to out_valid for a given multiplier
  function automatic int mul_lat(input logic [31:0] b);
    int it;
    it = 1;
    for (int i = 0; i < 32; i++) if (b[i]) it = i + 1;
`ifndef MUL_EARLY_TERM_EN
    it = 32;
`endif
    return it + 1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op = '0; m_flags = '0; m_byte = 0; m_mul = 0; m_res = '0;
    m_pending = 0; m_accepted = 0;
  endtask

  // Advance the model by the clock edge that just happened
  task automatic model_step();
    bit rdy;
    rdy = (m_pending == 0) && (!m_valid || out_ready);
    m_accepted = in_valid && rdy;
    if (m_valid && out_ready) m_valid = 0;
    if (m_pending > 0) begin
      m_pending--;
      if (m_pending == 0) begin
        m_valid = 1; m_op = ALU_ADD; m_flags = p_flags; m_byte = 0; m_mul = 1; m_res = p_res;
      end
    end else if (m_accepted) begin
      case (optype)
        2'd1: begin
          m_valid = 1; m_op = ctrl[3] ? ALU_ADD : ALU_SUB; m_flags = 4'h0;
          m_byte = ctrl[2]; m_mul = 0;
        end
        2'd2: begin
          p_res     = op_a * op_b + (ctrl[1] ? op_c : 32'h0);
          p_flags   = ctrl[0] ? 4'b1100 : 4'b0000;
          m_pending = mul_lat(op_b);
        end
        default: begin
          m_valid = 1; m_op = ctrl[3:1];
          m_flags = (optype == 2'd0 && ctrl[0]) ? 4'hF : 4'h0;
          m_byte = 0; m_mul = 0;
        end
      endcase
    end
  endtask

  task automatic compare();
    check("out_valid", out_valid, m_valid);
    check("in_ready", in_ready, (m_pending == 0) && (!m_valid || out_ready));
    check("busy", busy, m_pending > 0);
    if (m_valid) begin
      check("alu_opcode", alu_opcode, m_op);
      check("flag_we", flag_we, m_flags);
      check("byte_en", byte_en, m_byte);
      check("is_mul", is_mul, m_mul);
      if (m_mul) check("mul_result", mul_result, m_res);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    compare();
  endtask

  initial begin
    int n;
    rst = 1; in_valid = 0; optype = 0; ctrl = 0; op_a = 0; op_b = 0; op_c = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_flag_we", flag_we, 0);
    check("rst_byte_en", byte_en, 0);
    check("rst_is_mul", is_mul, 0);
    check("rst_mul_result", mul_result, 0);
    check("rst_busy", busy, 0);
    rst = 0; out_ready = 1;

    // DATA op=5 S=1
    in_valid = 1; optype = 2'd0; ctrl = 4'b1011; tick(); in_valid = 0;
    check("data_valid", out_valid, 1);
    check("data_opcode", alu_opcode, 5);
    check("data_flags", flag_we, 4'hF);

    // LDSTR down/byte, then up
    in_valid = 1; optype = 2'd1; ctrl = 4'b0100; tick();
    check("ldstr_sub_op", alu_opcode, ALU_SUB);
    check("ldstr_byte", byte_en, 1);
    check("ldstr_flags", flag_we, 0);
    ctrl = 4'b1000; tick(); in_valid = 0;
    check("ldstr_add_op", alu_opcode, ALU_ADD);
    check("ldstr_word", byte_en, 0);
    tick();

    // MUL 7*6 with S
    in_valid = 1; optype = 2'd2; ctrl = 4'b0001; op_a = 7; op_b = 6; op_c = 99; tick(); in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("mul_latency", n, LAT_7X6);
    check("mul_result_42", mul_result, 42);
    check("mul_flags", flag_we, 4'b1100);
    check("mul_is_mul", is_mul, 1);
    tick();

    // MLA wrap, with a DATA presented while busy
    in_valid = 1; optype = 2'd2; ctrl = 4'b0010; op_a = 32'hFFFFFFFF; op_b = 2; op_c = 5; tick();
    optype = 2'd0; ctrl = 4'b0011; tick();
    check("mla_in_ready_busy", in_ready, 0);
    check("mla_busy", busy, 1);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("mla_result", mul_result, 32'h00000003);
    check("mla_flags", flag_we, 0);
    tick(); in_valid = 0;
    check("held_data_op", alu_opcode, 1);
    tick();

    // Stall for 5 cycles with a second DATA waiting
    out_ready = 0; in_valid = 1; optype = 2'd0; ctrl = 4'b1101; tick();
    ctrl = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_op", alu_opcode, 6);
      check("stall_flags", flag_we, 4'hF);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1; tick(); in_valid = 0;
    check("b2b_valid", out_valid, 1);
    check("b2b_op", alu_opcode, 2);
    check("b2b_flags", flag_we, 0);
    tick();

    // Reset during a multiply
    in_valid = 1; optype = 2'd2; ctrl = 4'b0000; op_a = 3; op_b = 32'hFFFFFFFF; tick(); in_valid = 0;
    repeat (10) tick();
    #2 rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    in_valid = 1; optype = 2'd0; ctrl = 4'b0111; tick(); in_valid = 0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_op", alu_opcode, 3);
    check("post_rst_flags", flag_we, 4'hF);
    tick();

    // Randomized traffic; decode holds an instruction until it is taken
    m_accepted = 0;
    for (int c = 0; c < 2500; c++) begin
      if (!in_valid || m_accepted) begin
        in_valid = ($urandom_range(0, 2) != 0);
        optype   = 2'($urandom_range(0, 3));
        ctrl     = 4'($urandom);
        op_a     = $urandom;
        op_c     = $urandom;
        case ($urandom_range(0, 3))
          0: op_b = 32'h0;
          1: op_b = 32'h1 << $urandom_range(0, 31);
          2: op_b = $urandom & 32'hFF;
          default: op_b = $urandom;
        endcase
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_issue_seq
`default_nettype wire
